mmul_parallel_out_packer: RTL and testbench

- Downstream stage of the mmul_parallel engine.
- Consumes the engine's 32-bit out_r result stream and packs PACK_FACTOR consecutive results into one wide word for the streamer/TCDM sink.
- Counts the beats of one job and pads the final partial word. Pulses done once the last packed word has been accepted downstream.
- Sits between the engine and the hwpe_stream source, inside the mmul_parallel wrapper.

---
 rtl/mmul_parallel_out_packer_pkg.sv | 28 ++
 rtl/mmul_parallel_out_packer_out_reg.sv | 56 +++++
 rtl/mmul_parallel_out_packer.sv | 212 +++++++++++++++++++++
 tb/tb_mmul_parallel_out_packer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmul_parallel_out_packer_pkg.sv
// Shared types and constants for the mmul_parallel output packer.
//
// Contents:
//   MMUL_PARALLEL_PACK_FACTOR       default number of results per packed word
//   MMUL_PARALLEL_PACKER_CNT_WIDTH  default width of the beat counters
//   packer_state_t                  packer FSM states
//   packer_flags_t                  status bundle driven onto the top-level outputs
package mmul_parallel_out_packer_pkg;

    localparam int unsigned MMUL_PARALLEL_PACK_FACTOR      = 2;
    localparam int unsigned MMUL_PARALLEL_PACKER_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } packer_state_t;

    typedef struct packed {
        logic                                      busy;
        logic                                      done;
        logic [MMUL_PARALLEL_PACKER_CNT_WIDTH-1:0] cnt_in;
        logic [MMUL_PARALLEL_PACKER_CNT_WIDTH-1:0] cnt_out;
        logic                                      ovf;
    } packer_flags_t;

endpackage

// File: rtl/mmul_parallel_out_packer_out_reg.sv
// One-entry output holding register with a valid/ready interface.
//
// Handshake: a word is transferred on every clock edge where valid_o and
// ready_i are both high. Once valid_o is raised, valid_o/data_o/strb_o hold
// their values until that transfer happens; only reset or clear_i may drop
// a pending word.
//
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   clear_i         synchronous soft clear (drops any pending word)
//   load_i          write load_data_i/load_strb_i into the register
//   can_load_o      register is empty or drains this cycle
//   valid_o/ready_i output handshake
//   data_o/strb_o   held word and byte strobe
module mmul_parallel_out_packer_out_reg #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    load_i,
    input  logic [DATA_WIDTH-1:0]   load_data_i,
    input  logic [DATA_WIDTH/8-1:0] load_strb_i,
    output logic                    can_load_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic [DATA_WIDTH/8-1:0] strb_o
);

    logic                    valid_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH/8-1:0] strb_q;

    // A new word may be written in the same cycle the held word leaves.
    assign can_load_o = !valid_q || ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            strb_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= load_data_i;
            strb_q  <= load_strb_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign strb_o  = strb_q;

endmodule

// File: rtl/mmul_parallel_out_packer.sv
// Output packer of the mmul_parallel engine: packs PACK_FACTOR consecutive
// IN_WIDTH results into one OUT_WIDTH word (lane 0 in the LSBs), pads the
// final partial word with zero data / zero strobe, counts the job's beats
// and pulses done_o once the last packed word has been accepted.
//
// Handshake (both streams): a beat transfers on a clock edge where valid and
// ready are both high; valid never depends on ready, and a raised valid and
// its data hold until the transfer.
//
// Ports:
//   clk_i, rst_ni, clear_i    clock, sync active-low reset, soft clear
//   start_i, n_beats_i        job start pulse and result count
//   in_valid_i/in_ready_o     engine result stream, in_data_i (in_strb_i ignored)
//   out_valid_o/out_ready_i   packed stream, out_data_o, out_strb_o
//   busy_o, done_o            FSM not IDLE / one-cycle end-of-job pulse
//   cnt_in_o, cnt_out_o       results accepted / packed words delivered
//   ovf_o                     only with MMUL_PARALLEL_PACKER_OVF_CHECK_EN defined:
//                             sticky flag for valid input beyond the job length
module mmul_parallel_out_packer
    import mmul_parallel_out_packer_pkg::*;
#(
    parameter int unsigned IN_WIDTH    = 32,
    parameter int unsigned PACK_FACTOR = MMUL_PARALLEL_PACK_FACTOR,
    parameter int unsigned OUT_WIDTH   = IN_WIDTH * PACK_FACTOR,
    parameter int unsigned CNT_WIDTH   = MMUL_PARALLEL_PACKER_CNT_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [CNT_WIDTH-1:0]   n_beats_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [IN_WIDTH-1:0]    in_data_i,
    input  logic [IN_WIDTH/8-1:0]  in_strb_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [OUT_WIDTH-1:0]   out_data_o,
    output logic [OUT_WIDTH/8-1:0] out_strb_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CNT_WIDTH-1:0]   cnt_in_o,
    output logic [CNT_WIDTH-1:0]   cnt_out_o
`ifdef MMUL_PARALLEL_PACKER_OVF_CHECK_EN
    ,
    output logic                   ovf_o
`endif
);

    localparam int unsigned LANE_W    = $clog2(PACK_FACTOR);
    localparam int unsigned IN_STRB_W = IN_WIDTH / 8;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK_FACTOR - 1);

    packer_state_t                          state_q;
    logic [CNT_WIDTH-1:0]                   n_beats_q;
    logic [CNT_WIDTH-1:0]                   cnt_in_q;
    logic [CNT_WIDTH-1:0]                   cnt_out_q;
    logic [LANE_W-1:0]                      lane_q;
    logic [PACK_FACTOR-1:0][IN_WIDTH-1:0]   pack_q;

    logic                   last_beat;
    logic                   emit_beat;
    logic                   in_ready;
    logic                   in_fire;
    logic                   out_fire;
    logic                   out_can_load;
    logic [OUT_WIDTH-1:0]   load_data;
    logic [OUT_WIDTH/8-1:0] load_strb;
    packer_flags_t          flags;

    assign last_beat = (cnt_in_q == n_beats_q - CNT_WIDTH'(1));
    assign emit_beat = (lane_q == LAST_LANE) || last_beat;

    // Only a beat that completes a word needs room in the output register;
    // that includes a short final word, so the check is on emit_beat rather
    // than on the lane index alone (otherwise a held word could be overwritten).
    assign in_ready = (state_q == RUN) && (!emit_beat || out_can_load);
    assign in_fire  = in_valid_i && in_ready;
    assign out_fire = out_valid_o && out_ready_i;

    // Word handed to the output register: stored lanes below the current
    // one, the current beat in its own lane, zero data/strobe above it.
    always_comb begin
        load_data = '0;
        load_strb = '0;
        for (int j = 0; j < PACK_FACTOR; j++) begin
            if (LANE_W'(j) < lane_q) begin
                load_data[j*IN_WIDTH +: IN_WIDTH]   = pack_q[j];
                load_strb[j*IN_STRB_W +: IN_STRB_W] = '1;
            end else if (LANE_W'(j) == lane_q) begin
                load_data[j*IN_WIDTH +: IN_WIDTH]   = in_data_i;
                load_strb[j*IN_STRB_W +: IN_STRB_W] = '1;
            end
        end
    end

    mmul_parallel_out_packer_out_reg #(
        .DATA_WIDTH (OUT_WIDTH)
    ) u_out_reg (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .load_i      (in_fire && emit_beat),
        .load_data_i (load_data),
        .load_strb_i (load_strb),
        .can_load_o  (out_can_load),
        .valid_o     (out_valid_o),
        .ready_i     (out_ready_i),
        .data_o      (out_data_o),
        .strb_o      (out_strb_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q   <= IDLE;
            n_beats_q <= '0;
            cnt_in_q  <= '0;
            cnt_out_q <= '0;
            lane_q    <= '0;
            pack_q    <= '0;
        end else begin
            if (out_fire) begin
                cnt_out_q <= cnt_out_q + CNT_WIDTH'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        n_beats_q <= n_beats_i;
                        cnt_in_q  <= '0;
                        cnt_out_q <= '0;
                        lane_q    <= '0;
                        // An empty job has nothing to pack; it passes through
                        // DRAIN (register already empty) straight to DONE.
                        state_q   <= (n_beats_i == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        cnt_in_q <= cnt_in_q + CNT_WIDTH'(1);
                        if (emit_beat) begin
                            lane_q <= '0;
                            if (last_beat) begin
                                state_q <= DRAIN;
                            end
                        end else begin
                            pack_q[lane_q] <= in_data_i;
                            lane_q         <= lane_q + LANE_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_can_load) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MMUL_PARALLEL_PACKER_OVF_CHECK_EN
    logic ovf_q;
    logic done_d_q;

    // done_d_q marks the IDLE cycle right after done_o, where a trailing
    // engine beat still counts as an overrun of the finished job.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            ovf_q    <= 1'b0;
            done_d_q <= 1'b0;
        end else begin
            done_d_q <= (state_q == DONE);
            if (start_i) begin
                ovf_q <= 1'b0;
            end else if (in_valid_i && ((state_q == DRAIN) || (state_q == DONE) ||
                                        ((state_q == IDLE) && done_d_q))) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign ovf_o = flags.ovf;
`endif

    always_comb begin
        flags.busy    = (state_q != IDLE);
        flags.done    = (state_q == DONE);
        flags.cnt_in  = cnt_in_q;
        flags.cnt_out = cnt_out_q;
`ifdef MMUL_PARALLEL_PACKER_OVF_CHECK_EN
        flags.ovf     = ovf_q;
`else
        flags.ovf     = 1'b0;
`endif
    end

    assign in_ready_o = in_ready;
    assign busy_o     = flags.busy;
    assign done_o     = flags.done;
    assign cnt_in_o   = flags.cnt_in;
    assign cnt_out_o  = flags.cnt_out;

    // Input strobes are deliberately ignored: every engine result is full width.
    logic unused_inputs;
    assign unused_inputs = ^{in_strb_i, flags.ovf};

endmodule

// File: tb/tb_mmul_parallel_out_packer.sv
// Testbench for mmul_parallel_out_packer (IN_WIDTH=32, PACK_FACTOR=2).
// Expected packed words are built from each job's beat list by chunking it
// into groups of PACK_FACTOR; a compare process checks every output transfer
// and the stable-until-ready rule. Define MMUL_PARALLEL_PACKER_OVF_CHECK_EN
// to also exercise ovf_o.
module tb_mmul_parallel_out_packer;

    localparam int IN_W = 32;
    localparam int PF   = 2;
    localparam int OW   = IN_W * PF;
    localparam int SW   = OW / 8;
    localparam int CW   = 16;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear = 1'b0;
    logic            start = 1'b0;
    logic [CW-1:0]   n_beats = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [IN_W-1:0] in_data = '0;
    logic [IN_W/8-1:0] in_strb = '1;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [OW-1:0]   out_data;
    logic [SW-1:0]   out_strb;
    logic            busy;
    logic            done;
    logic [CW-1:0]   cnt_in;
    logic [CW-1:0]   cnt_out;
`ifdef MMUL_PARALLEL_PACKER_OVF_CHECK_EN
    logic            ovf;
`endif

    always #5 clk = ~clk;

    mmul_parallel_out_packer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .start_i     (start),
        .n_beats_i   (n_beats),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_strb_i   (in_strb),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_strb_o  (out_strb),
        .busy_o      (busy),
        .done_o      (done),
        .cnt_in_o    (cnt_in),
        .cnt_out_o   (cnt_out)
`ifdef MMUL_PARALLEL_PACKER_OVF_CHECK_EN
        ,
        .ovf_o       (ovf)
`endif
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [OW-1:0] exp_q[$];
    logic [SW-1:0] exp_strb_q[$];
    logic [OW-1:0] got_q[$];
    logic [SW-1:0] got_strb_q[$];

    int cyc = 0;
    int hs_edge = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    bit prev_hold = 0;
    logic [OW-1:0] prev_data = '0;
    bit saw_block = 0;

    int rdy_mode = 0;   // 0: always ready, 1: random, 2: one 5-cycle stall
    int stall_left = 0;
    bit stall_done = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Build the expected packed words of a job straight from its beat list.
    task automatic push_model(input logic [IN_W-1:0] d[$]);
        logic [OW-1:0] w;
        logic [SW-1:0] s;
        int n = d.size();
        for (int b = 0; b < n; b += PF) begin
            w = '0;
            s = '0;
            for (int l = 0; l < PF; l++) begin
                if (b + l < n) begin
                    w[l*IN_W +: IN_W] = d[b+l];
                    s[l*(IN_W/8) +: (IN_W/8)] = '1;
                end
            end
            exp_q.push_back(w);
            exp_strb_q.push_back(s);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n && !clear) begin
            if (prev_hold) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got %h expected no word", out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                    check("out_strb", 64'(out_strb), 64'(exp_strb_q.pop_front()));
                end
                got_q.push_back(out_data);
                got_strb_q.push_back(out_strb);
                hs_edge = cyc + 1;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (rdy_mode == 2 && out_valid && !out_ready && in_valid && !in_ready)
                saw_block = 1;
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end else begin
            prev_hold = 0;
        end
    end

    // ---------------- output ready driver ----------------
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 2 && !stall_done && out_valid) begin
            stall_left = 5;
            stall_done = 1;
        end
        if (rdy_mode == 0) out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        else begin
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        n_beats = CW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one beat and hold it until accepted (in_valid left high).
    task automatic send_beat(input logic [IN_W-1:0] d, output bit ok);
        in_valid = 1'b1;
        in_data = d;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        tick();
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 500; i++) begin
            if (done_cnt != d0) break;
            @(negedge clk);
            #1;
        end
        check("done_seen", 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic run_job(input logic [IN_W-1:0] d[$], input bit gaps);
        int n = d.size();
        int d0 = done_cnt;
        bit ok;
        push_model(d);
        got_q.delete();
        got_strb_q.delete();
        do_start(n);
        check("busy_after_start", 64'(busy), 64'd1);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            send_beat(d[i], ok);
            check("in_accepted", 64'(ok), 64'd1);
        end
        in_valid = 1'b0;
        wait_done(d0);
        if (n > 0) check("done_latency", 64'(done_cyc), 64'(hs_edge));
        check("cnt_in", 64'(cnt_in), 64'(n));
        check("cnt_out", 64'(cnt_out), 64'((n + PF - 1) / PF));
        check("model_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
        check("cnt_out_held", 64'(cnt_out), 64'((n + PF - 1) / PF));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [IN_W-1:0] dq[$];
        bit ok;
        int d0;

        // reset
        repeat (3) tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_cnt_in", 64'(cnt_in), 64'd0);
        check("rst_cnt_out", 64'(cnt_out), 64'd0);
        rst_n = 1'b1;
        rdy_mode = 0;
        tick();
        in_valid = 1'b1;
        in_data = 32'hdead_beef;
        #2;
        check("idle_stalls_input", 64'(in_ready), 64'd0);
        tick();
        in_valid = 1'b0;

        // N=4, 1..4, always ready
        dq.delete();
        for (int i = 1; i <= 4; i++) dq.push_back(IN_W'(i));
        run_job(dq, 0);
        check("n4_word0", got_q[0], 64'h00000002_00000001);
        check("n4_word1", got_q[1], 64'h00000004_00000003);
        check("n4_strb1", 64'(got_strb_q[1]), 64'hFF);

        // N=3, partial last word
        dq.delete();
        for (int i = 1; i <= 3; i++) dq.push_back(IN_W'(i));
        run_job(dq, 0);
        check("n3_word1", got_q[1], 64'h00000000_00000003);
        check("n3_strb1", 64'(got_strb_q[1]), 64'h0F);

        // N=8 with a 5-cycle output stall after the first word
        rdy_mode = 2;
        stall_done = 0;
        saw_block = 0;
        dq.delete();
        for (int i = 1; i <= 8; i++) dq.push_back(IN_W'(32'h100 + i));
        run_job(dq, 0);
        check("stall_blocks_input", 64'(saw_block), 64'd1);
        check("stall_word_count", 64'(got_q.size()), 64'd4);
        check("stall_word3", got_q[3], 64'h00000108_00000107);
        rdy_mode = 0;

        // N=0: DRAIN then DONE, no output
        d0 = done_cnt;
        got_q.delete();
        do_start(0);
        check("n0_busy_c1", 64'(busy), 64'd1);
        check("n0_done_c1", 64'(done), 64'd0);
        tick();
        check("n0_busy_c2", 64'(busy), 64'd1);
        check("n0_done_c2", 64'(done), 64'd1);
        tick();
        check("n0_busy_c3", 64'(busy), 64'd0);
        check("n0_done_c3", 64'(done), 64'd0);
        check("n0_done_count", 64'(done_cnt - d0), 64'd1);
        check("n0_no_output", 64'(got_q.size()), 64'd0);

        // clear after 3 beats of N=8
        dq.delete();
        dq.push_back(32'h11);
        dq.push_back(32'h22);
        push_model(dq);
        do_start(8);
        send_beat(32'h11, ok);
        send_beat(32'h22, ok);
        send_beat(32'h33, ok);
        in_valid = 1'b0;
        tick();
        tick();
        d0 = done_cnt;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_out_valid", 64'(out_valid), 64'd0);
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_cnt_in", 64'(cnt_in), 64'd0);
        check("clr_cnt_out", 64'(cnt_out), 64'd0);
        repeat (5) tick();
        check("clr_no_done", 64'(done_cnt - d0), 64'd0);
        check("clr_first_word_out", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        exp_strb_q.delete();
        dq.delete();
        dq.push_back(32'haaaa_0001);
        dq.push_back(32'hbbbb_0002);
        run_job(dq, 0);
        check("post_clr_word", got_q[0], 64'hbbbb0002_aaaa0001);

        // randomized jobs with input gaps and random backpressure
        rdy_mode = 1;
        for (int j = 0; j < 12; j++) begin
            dq.delete();
            for (int i = 0; i < $urandom_range(1, 13); i++) dq.push_back($urandom);
            run_job(dq, 1);
        end
        rdy_mode = 0;

`ifdef MMUL_PARALLEL_PACKER_OVF_CHECK_EN
        // extra beat offered while draining sets the sticky overflow flag
        tick();
        dq.delete();
        dq.push_back(32'h1);
        dq.push_back(32'h2);
        push_model(dq);
        d0 = done_cnt;
        do_start(2);
        check("ovf_clear_at_start", 64'(ovf), 64'd0);
        send_beat(32'h1, ok);
        send_beat(32'h2, ok);
        in_data = 32'h3;
        tick();
        in_valid = 1'b0;
        wait_done(d0);
        tick();
        check("ovf_set", 64'(ovf), 64'd1);
        repeat (4) tick();
        check("ovf_sticky", 64'(ovf), 64'd1);
        dq.delete();
        dq.push_back(32'h7);
        dq.push_back(32'h8);
        run_job(dq, 0);
        check("ovf_cleared_by_start", 64'(ovf), 64'd0);
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
